// File: rtl/convolution_index_gen.sv
// Walks the (j, k) index space of z[k] = sum_j x[j]*y[k-j], one in-range pair per cycle,
// flagging the first and last term of each k for the downstream accumulator.
module convolution_index_gen #(
   parameter int DATA_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] sizeX_i,
   input  logic [DATA_WIDTH-1:0] sizeY_i,
   input  logic                  stall_i,
   output logic [DATA_WIDTH-1:0] j_o,
   output logic [DATA_WIDTH:0]   k_o,
   output logic                  valid_o,
   output logic                  first_o,
   output logic                  last_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [1:0]            dbg_state_o
);

   localparam int KW = DATA_WIDTH + 1;
   localparam logic [KW-1:0] ONE = KW'(1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   // Handshake: a pair is consumed on the rising edge where valid_o=1 and stall_i=0;
   // while stall_i=1 every output holds, so the same pair is re-presented.

   state_t                r_state, w_nxt_state;
   logic [DATA_WIDTH-1:0] r_size_x, w_nxt_size_x;
   logic [DATA_WIDTH-1:0] r_size_y, w_nxt_size_y;
   logic [DATA_WIDTH-1:0] r_j, w_nxt_j;
   logic [KW-1:0]         r_k, w_nxt_k;
   logic                  r_valid, w_nxt_valid;
   logic                  r_first, w_nxt_first;
   logic                  r_last, w_nxt_last;
   logic                  r_busy, w_nxt_busy;
   logic                  r_done, w_nxt_done;

   logic [KW-1:0] w_sx, w_sy, w_kmax, w_k_inc;
   logic [KW-1:0] w_jmax_k, w_jmin_kinc, w_jmax_kinc;
   logic [KW-1:0] w_j_ext, w_j_inc;

   // Lowest j for a given k; k+1 >= sy avoids a signed k-sy+1.
   function automatic logic [KW-1:0] f_jmin(input logic [KW-1:0] k, input logic [KW-1:0] sy);
      f_jmin = ((k + ONE) >= sy) ? (k + ONE - sy) : '0;
   endfunction

   function automatic logic [KW-1:0] f_jmax(input logic [KW-1:0] k, input logic [KW-1:0] sx);
      f_jmax = (k < (sx - ONE)) ? k : (sx - ONE);
   endfunction

   assign w_sx        = {1'b0, r_size_x};
   assign w_sy        = {1'b0, r_size_y};
   assign w_kmax      = w_sx + w_sy - KW'(2);
   assign w_k_inc     = r_k + ONE;
   assign w_j_ext     = {1'b0, r_j};
   assign w_j_inc     = w_j_ext + ONE;
   assign w_jmax_k    = f_jmax(r_k, w_sx);
   assign w_jmin_kinc = f_jmin(w_k_inc, w_sy);
   assign w_jmax_kinc = f_jmax(w_k_inc, w_sx);

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_size_x = r_size_x;
      w_nxt_size_y = r_size_y;
      w_nxt_j      = r_j;
      w_nxt_k      = r_k;
      w_nxt_valid  = r_valid;
      w_nxt_first  = r_first;
      w_nxt_last   = r_last;
      w_nxt_busy   = r_busy;
      w_nxt_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_nxt_size_x = sizeX_i;
               w_nxt_size_y = sizeY_i;
               w_nxt_busy   = 1'b1;
               if (sizeX_i == '0 || sizeY_i == '0) begin
                  w_nxt_state = S_DONE;
                  w_nxt_done  = 1'b1;
               end else begin
                  // k=0 always has exactly one term, j=0.
                  w_nxt_state = S_RUN;
                  w_nxt_j     = '0;
                  w_nxt_k     = '0;
                  w_nxt_valid = 1'b1;
                  w_nxt_first = 1'b1;
                  w_nxt_last  = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (!stall_i) begin
               if (w_j_ext < w_jmax_k) begin
                  w_nxt_j     = w_j_inc[DATA_WIDTH-1:0];
                  w_nxt_first = 1'b0;
                  w_nxt_last  = (w_j_inc == w_jmax_k);
               end else if (r_k < w_kmax) begin
                  w_nxt_k     = w_k_inc;
                  w_nxt_j     = w_jmin_kinc[DATA_WIDTH-1:0];
                  w_nxt_first = 1'b1;
                  w_nxt_last  = (w_jmin_kinc == w_jmax_kinc);
               end else begin
                  w_nxt_state = S_DONE;
                  w_nxt_valid = 1'b0;
                  w_nxt_first = 1'b0;
                  w_nxt_last  = 1'b0;
                  w_nxt_done  = 1'b1;
               end
            end
         end
         S_DONE: begin
            w_nxt_state = S_IDLE;
            w_nxt_busy  = 1'b0;
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_valid = 1'b0;
            w_nxt_busy  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_size_x <= '0;
         r_size_y <= '0;
         r_j      <= '0;
         r_k      <= '0;
         r_valid  <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_size_x <= w_nxt_size_x;
         r_size_y <= w_nxt_size_y;
         r_j      <= w_nxt_j;
         r_k      <= w_nxt_k;
         r_valid  <= w_nxt_valid;
         r_first  <= w_nxt_first;
         r_last   <= w_nxt_last;
         r_busy   <= w_nxt_busy;
         r_done   <= w_nxt_done;
      end
   end

   assign j_o         = r_j;
   assign k_o         = r_k;
   assign valid_o     = r_valid;
   assign first_o     = r_first;
   assign last_o      = r_last;
   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_convolution_index_gen.sv
// Bench for convolution_index_gen: every job is compared beat by beat against a list of
// (j, k, first, last) built directly from the convolution index bounds.
module tb_convolution_index_gen;

   localparam int DW = 5;
   localparam int W  = DW + (DW + 1) + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          stall_i = 1'b0;
   logic [DW-1:0] sizeX_i = '0;
   logic [DW-1:0] sizeY_i = '0;
   logic [DW-1:0] j_o;
   logic [DW:0]   k_o;
   logic          valid_o, first_o, last_o, busy_o, done_o;
   logic [1:0]    dbg_state_o;

   convolution_index_gen #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i),
      .sizeX_i(sizeX_i), .sizeY_i(sizeY_i), .stall_i(stall_i),
      .j_o(j_o), .k_o(k_o), .valid_o(valid_o), .first_o(first_o), .last_o(last_o),
      .busy_o(busy_o), .done_o(done_o), .dbg_state_o(dbg_state_o)
   );

   // clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: every j with 0<=j<sx and 0<=k-j<sy, grouped by k in ascending order.
   task automatic build_model(input int sx, input int sy);
      logic [DW-1:0] jj;
      logic [DW:0]   kk;
      exp_q.delete();
      for (int k = 0; k <= sx + sy - 2; k++) begin
         int js[$];
         for (int j = 0; j < sx; j++)
            if (k - j >= 0 && k - j < sy) js.push_back(j);
         for (int i = 0; i < js.size(); i++) begin
            jj = js[i][DW-1:0];
            kk = k[DW:0];
            exp_q.push_back({jj, kk, (i == 0), (i == js.size() - 1)});
         end
      end
   endtask

   // Drivers change inputs on the falling edge; outputs are sampled there too.
   // stall_mode: 0 none, 1 random, 2 hold pair (1,2) for 3 cycles.
   task automatic run_job(input int sx, input int sy, input int stall_mode, input bit toggle_start,
                          output int beats, output int held12,
                          output logic [DW-1:0] last_j, output logic [DW:0] last_k);
      int cyc = 0;
      int nstall = 0;
      int stall_run = 0;
      bit fin = 0;
      bit stl;
      logic [W-1:0] e;
      beats = 0; held12 = 0; last_j = '0; last_k = '0;
      build_model(sx, sy);
      @(negedge clk);
      start_i = 1'b1; sizeX_i = sx[DW-1:0]; sizeY_i = sy[DW-1:0]; stall_i = 1'b0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         start_i = toggle_start ? 1'($urandom_range(0, 1)) : 1'b0;
         if (toggle_start) begin
            sizeX_i = DW'($urandom);
            sizeY_i = DW'($urandom);
         end
         check_val("busy_during_job", busy_o, 1);
         stl = 1'b0;
         if (valid_o) begin
            if (exp_q.size() == 0) begin
               check_val("extra_beat", valid_o, 0);
               fin = 1;
            end else begin
               e = exp_q[0];
               check_val("pair_j_k_first_last", {j_o, k_o, first_o, last_o}, e);
               if (j_o == 1 && k_o == 2) held12++;
               case (stall_mode)
                  1: stl = ($urandom_range(0, 3) == 0);
                  2: begin
                     stl = (j_o == 1 && k_o == 2 && stall_run < 3);
                     if (stl) stall_run++;
                  end
                  default: stl = 1'b0;
               endcase
               if (stl) nstall++;
               else begin
                  void'(exp_q.pop_front());
                  beats++;
                  last_j = j_o;
                  last_k = k_o;
               end
            end
         end
         stall_i = stl;
         if (done_o) begin
            check_val("done_all_beats", exp_q.size(), 0);
            check_val("done_latency", cyc, sx * sy + nstall + 1);
            check_val("done_valid_low", valid_o, 0);
            fin = 1;
         end else if (cyc > 3000) begin
            check_val("timeout_done", done_o, 1);
            fin = 1;
         end
      end
      @(negedge clk);
      stall_i = 1'b0; start_i = 1'b0;
      check_val("busy_after_done", busy_o, 0);
      check_val("done_one_cycle", done_o, 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val(tag, {j_o, k_o, valid_o, first_o, last_o, busy_o, done_o}, 0);
   endtask

   initial begin
      int b, h;
      logic [DW-1:0] lj;
      logic [DW:0]   lk;

      repeat (2) @(negedge clk);
      check_idle_outputs("reset_values");
      check_val("reset_state", dbg_state_o, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("idle_after_reset");

      run_job(3, 2, 0, 0, b, h, lj, lk);
      check_val("beats_3x2", b, 6);
      check_val("end_3x2", {lj, lk}, {5'd2, 6'd3});

      run_job(1, 1, 0, 0, b, h, lj, lk);
      check_val("beats_1x1", b, 1);

      run_job(0, 4, 0, 0, b, h, lj, lk);
      check_val("beats_0x4", b, 0);
      run_job(4, 0, 0, 0, b, h, lj, lk);
      check_val("beats_4x0", b, 0);

      run_job(4, 4, 2, 0, b, h, lj, lk);
      check_val("beats_4x4_stall", b, 16);
      check_val("held_1_2", h, 4);

      // Asynchronous abort in the middle of a 5x5 job.
      @(negedge clk);
      start_i = 1'b1; sizeX_i = 5'd5; sizeY_i = 5'd5;
      @(negedge clk);
      start_i = 1'b0;
      repeat (6) @(negedge clk);
      check_val("running_before_abort", valid_o, 1);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("abort_async");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("no_done_after_abort", {done_o, valid_o, busy_o}, 0);
      end

      run_job(2, 3, 0, 0, b, h, lj, lk);
      check_val("beats_2x3_after_abort", b, 6);

      run_job(31, 31, 0, 1, b, h, lj, lk);
      check_val("beats_31x31", b, 961);
      check_val("end_31x31", {lj, lk}, {5'd30, 6'd60});

      for (int n = 0; n < 8; n++) begin
         int sx, sy;
         sx = $urandom_range(0, 12);
         sy = $urandom_range(0, 12);
         run_job(sx, sy, 1, 0, b, h, lj, lk);
         check_val("beats_random", b, sx * sy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
